// File: rtl/module_7seg_pkg.sv
// Shared types and active-high segment patterns for the 4-digit 7-segment scanner.
// Bit order of every pattern is {g,f,e,d,c,b,a}.
package module_7seg_pkg;

  typedef logic [1:0] digit_idx_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'h3F;
  localparam seg_t SEG_1    = 7'h06;
  localparam seg_t SEG_2    = 7'h5B;
  localparam seg_t SEG_3    = 7'h4F;
  localparam seg_t SEG_4    = 7'h66;
  localparam seg_t SEG_5    = 7'h6D;
  localparam seg_t SEG_6    = 7'h7D;
  localparam seg_t SEG_7    = 7'h07;
  localparam seg_t SEG_8    = 7'h7F;
  localparam seg_t SEG_9    = 7'h6F;
  localparam seg_t SEG_DASH = 7'h40;
  localparam seg_t SEG_OFF  = 7'h00;

endpackage

// File: rtl/module_7seg_scan_if.sv
// Packed-BCD update bus from the binary-to-BCD converter into the display scanner.
interface module_7seg_scan_if;

  logic [15:0] bcd;
  logic        valid;

  modport master (output bcd, output valid);
  modport slave  (input  bcd, input  valid);

endinterface

// File: rtl/module_7seg_scan_bcd_to_7seg.sv
// Combinational BCD nibble to active-high 7-segment decoder with a blank override.
module module_bcd_to_7seg
  import module_7seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output seg_t       o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    if (i_blank) begin
      o_seg = SEG_OFF;
    end else begin
      case (i_nibble)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/module_7seg_scan.sv
// Time-multiplexed 4-digit 7-segment driver with frame-synchronous updates,
// leading-zero blanking and a per-slot anti-ghosting dark window.
module module_7seg_scan
  import module_7seg_pkg::*;
#(
  parameter int unsigned DIV_COUNT      = 27000,
  parameter int unsigned GHOST_TICKS    = 16,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1,
  parameter int unsigned BLANK_LEADING  = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  module_7seg_scan_if.slave        i_bus,
  input  logic                     i_enable,
  output seg_t                     o_seg,
  output logic [3:0]               o_an,
  output logic                     o_frame
);

  localparam int unsigned CNT_W = $clog2(DIV_COUNT);

  // XOR masks: the "off" level of each output group equals its polarity mask.
  localparam seg_t       SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_POL  = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  if (DIV_COUNT < 4) begin : g_bad_div
    $error("DIV_COUNT must be at least 4");
  end
  if (GHOST_TICKS >= DIV_COUNT) begin : g_bad_ghost
    $error("GHOST_TICKS must be less than DIV_COUNT");
  end

  logic [CNT_W-1:0] r_cnt;
  digit_idx_t       r_idx;
  logic [15:0]      r_shadow;
  logic [15:0]      r_disp;
  seg_t             r_seg;
  logic [3:0]       r_an;
  logic             r_frame;

  logic             w_tc;
  logic             w_frame_tc;
  logic             w_lit;
  logic [3:0]       w_nibble;
  logic             w_blank;
  logic [3:0]       w_an_hot;
  seg_t             w_seg_hi;

  assign w_tc       = (r_cnt == CNT_W'(DIV_COUNT - 1));
  assign w_frame_tc = w_tc && (r_idx == 2'd3);
  assign w_lit      = i_enable && (r_cnt >= CNT_W'(GHOST_TICKS));
  assign w_an_hot   = 4'b0001 << r_idx;

  // A digit is blank when it and every more-significant nibble are zero.
  always_comb begin
    w_nibble = r_disp[3:0];
    w_blank  = 1'b0;
    case (r_idx)
      2'd0: w_nibble = r_disp[3:0];
      2'd1: begin
        w_nibble = r_disp[7:4];
        w_blank  = (r_disp[15:4] == 12'h000);
      end
      2'd2: begin
        w_nibble = r_disp[11:8];
        w_blank  = (r_disp[15:8] == 8'h00);
      end
      default: begin
        w_nibble = r_disp[15:12];
        w_blank  = (r_disp[15:12] == 4'h0);
      end
    endcase
    if (BLANK_LEADING == 0) begin
      w_blank = 1'b0;
    end
  end

  module_bcd_to_7seg u_dec (
    .i_nibble (w_nibble),
    .i_blank  (w_blank),
    .o_seg    (w_seg_hi)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_disp   <= '0;
      r_seg    <= SEG_POL;
      r_an     <= AN_POL;
      r_frame  <= 1'b0;
    end else begin
      r_cnt <= w_tc ? '0 : r_cnt + CNT_W'(1);
      if (w_tc) begin
        r_idx <= r_idx + 2'd1;
      end
      // Display takes the pre-edge shadow, so a coincident strobe waits a frame.
      if (w_frame_tc) begin
        r_disp <= r_shadow;
      end
      if (i_bus.valid) begin
        r_shadow <= i_bus.bcd;
      end
      r_frame <= w_frame_tc;
      r_an    <= w_lit ? (w_an_hot ^ AN_POL) : AN_POL;
      r_seg   <= w_lit ? (w_seg_hi ^ SEG_POL) : SEG_POL;
    end
  end

  assign o_seg   = r_seg;
  assign o_an    = r_an;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_module_7seg_scan.sv
// Self-checking bench: cycle scoreboard from a behavioural model plus directed frame captures.
module tb_module_7seg_scan;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [6:0] o_seg;
  logic [3:0] o_an;
  logic       o_frame;

  module_7seg_scan_if bus ();

  module_7seg_scan #(
    .DIV_COUNT      (8),
    .GHOST_TICKS    (2),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1),
    .BLANK_LEADING  (1)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_bus    (bus),
    .i_enable (enable),
    .o_seg    (o_seg),
    .o_an     (o_an),
    .o_frame  (o_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Active-high reference pattern for digit k of display word d, blanking included.
  function automatic logic [6:0] model_seg(input logic [15:0] d, input logic [1:0] k);
    int          sh;
    logic [15:0] hi;
    logic [3:0]  nib;
    sh  = 4 * int'(k);
    hi  = d >> sh;
    nib = hi[3:0];
    if (k != 2'd0 && hi == 16'h0000) return 7'h00;
    case (nib)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame;
  } exp_t;

  exp_t        sb_q[$];
  logic [2:0]  m_cnt;
  logic [1:0]  m_idx;
  logic [15:0] m_shadow;
  logic [15:0] m_disp;

  // Reference model: expectation for the outputs registered on this edge.
  always @(posedge clk) begin
    exp_t       e;
    logic [3:0] oh;
    if (rst) begin
      e = '{an: 4'hF, seg: 7'h7F, frame: 1'b0};
      m_cnt    <= 3'd0;
      m_idx    <= 2'd0;
      m_shadow <= 16'h0000;
      m_disp   <= 16'h0000;
    end else begin
      e.frame = (m_cnt == 3'd7) && (m_idx == 2'd3);
      if (!enable || m_cnt < 3'd2) begin
        e.an  = 4'hF;
        e.seg = 7'h7F;
      end else begin
        oh    = 4'b0001 << m_idx;
        e.an  = ~oh;
        e.seg = ~model_seg(m_disp, m_idx);
      end
      m_cnt <= m_cnt + 3'd1;
      if (m_cnt == 3'd7) begin
        m_idx <= m_idx + 2'd1;
        if (m_idx == 2'd3) m_disp <= m_shadow;
      end
      if (bus.valid) m_shadow <= bus.bcd;
    end
    sb_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_an", 16'(o_an), 16'(e.an));
      chk("sb_seg", 16'(o_seg), 16'(e.seg));
      chk("sb_frame", 16'(o_frame), 16'(e.frame));
    end
  end

  logic [6:0] cap_seg [4];

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (o_frame) seen = 1'b1;
    end
    chk("frame_seen", 16'(seen), 16'd1);
  endtask

  task automatic capture(input int n);
    logic [3:0] oh;
    for (int k = 0; k < 4; k++) cap_seg[k] = 7'h55;
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        oh = 4'b0001 << k;
        if (o_an == ~oh) cap_seg[k] = o_seg;
      end
    end
  endtask

  task automatic load(input logic [15:0] v);
    @(negedge clk);
    bus.bcd   = v;
    bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
  endtask

  task automatic chk_caps(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                          input logic [6:0] d1, input logic [6:0] d0);
    chk({tag, "_d3"}, 16'(cap_seg[3]), 16'(d3));
    chk({tag, "_d2"}, 16'(cap_seg[2]), 16'(d2));
    chk({tag, "_d1"}, 16'(cap_seg[1]), 16'(d1));
    chk({tag, "_d0"}, 16'(cap_seg[0]), 16'(d0));
  endtask

  task automatic startup_check(input string tag);
    @(negedge clk);
    chk({tag, "_c1_an"}, 16'(o_an), 16'hF);
    @(negedge clk);
    chk({tag, "_c2_an"}, 16'(o_an), 16'hF);
    @(negedge clk);
    chk({tag, "_c3_an"}, 16'(o_an), 16'hE);
    chk({tag, "_c3_seg"}, 16'(o_seg), 16'h40);
  endtask

  initial begin
    int frames;
    rst       = 1'b1;
    enable    = 1'b1;
    bus.bcd   = 16'h0000;
    bus.valid = 1'b0;

    // Reset held three cycles, then the first lit slot is digit 0 showing "0".
    repeat (3) @(negedge clk);
    chk("rst_an", 16'(o_an), 16'hF);
    chk("rst_seg", 16'(o_seg), 16'h7F);
    chk("rst_frame", 16'(o_frame), 16'h0);
    rst = 1'b0;
    startup_check("start");

    load(16'h1234);
    wait_frame();
    capture(32);
    chk_caps("v1234", 7'h79, 7'h24, 7'h30, 7'h19);
    frames = 0;
    repeat (64) begin
      @(negedge clk);
      if (o_frame) frames++;
    end
    chk("frames_per_64", 16'(frames), 16'd2);

    load(16'h0042);
    wait_frame();
    capture(32);
    chk_caps("v0042", 7'h7F, 7'h7F, 7'h19, 7'h24);

    load(16'h0000);
    wait_frame();
    capture(32);
    chk_caps("v0000", 7'h7F, 7'h7F, 7'h7F, 7'h40);

    load(16'h00A5);
    wait_frame();
    capture(32);
    chk_caps("v00A5", 7'h7F, 7'h7F, 7'h3F, 7'h12);

    // Mid-frame update must not tear the frame already being shown.
    load(16'h1111);
    wait_frame();
    capture(12);
    @(negedge clk);
    bus.bcd   = 16'h2222;
    bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    capture(18);
    chk("tear_d2", 16'(cap_seg[2]), 16'h79);
    chk("tear_d3", 16'(cap_seg[3]), 16'h79);
    chk("tear_frame", 16'(o_frame), 16'h1);
    capture(32);
    chk_caps("v2222", 7'h24, 7'h24, 7'h24, 7'h24);

    // Disable mid-slot: dark one cycle later, scan position preserved.
    wait_frame();
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_an", 16'(o_an), 16'hF);
    chk("dis_seg", 16'(o_seg), 16'h7F);
    repeat (9) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("reen_an", 16'(o_an), 16'hD);
    repeat (5) @(negedge clk);

    // Reset mid-slot restarts the scan from digit 0 with cleared registers.
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_an", 16'(o_an), 16'hF);
    chk("mid_rst_seg", 16'(o_seg), 16'h7F);
    chk("mid_rst_frame", 16'(o_frame), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    startup_check("restart");
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
